// File: rtl/mc_core_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_core_if
// Purpose  : Instruction-fetch bus between mc_core and its instruction memory.
// Revision : 1.0
// ============================================================================
interface mc_core_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mc_core.sv
`default_nettype none
// ============================================================================
// Module   : mc_core
// Purpose  : Two-cycle multicycle core executing ADD, ADDI and the six branches.
// Revision : 1.0
// ============================================================================
module mc_core #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    mc_core_if.master            imem,
    output logic                 retire,
    output logic                 halted,
    output logic                 illegal,
    output logic [XLEN-1:0]      dbg_pc,
    input  wire logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0]      dbg_rdata
);
    localparam int         c_AW    = $clog2(NREGS);
    localparam logic [5:0] c_NREGS = 6'(NREGS);

    // Every legal transition flips exactly one state bit, so decodes stay glitch-free.
    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_HALT  = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_retire;
    logic            r_illegal;
    logic [XLEN-1:0] r_regs [NREGS];

    logic [31:0]     w_inst;
    logic            w_is_add, w_is_addi, w_is_br;
    logic            w_rd_ok, w_rs1_ok, w_rs2_ok, w_idx_bad;
    logic [XLEN-1:0] w_rs1, w_rs2, w_imm_i, w_imm_b, w_target, w_pc_next, w_wdata;
    logic            w_taken, w_fault, w_wen;
    logic [c_AW-1:0] w_rd_idx;

    // Legality is judged on the incoming word during FETCH so retire can be a flop.
    assign w_inst    = (r_state == S_FETCH) ? imem.imem_rdata : r_ir;

    assign w_is_add  = (w_inst[6:0] == 7'b0110011) && (w_inst[14:12] == 3'b000)
                       && (w_inst[31:25] == 7'b0000000);
    assign w_is_addi = (w_inst[6:0] == 7'b0010011) && (w_inst[14:12] == 3'b000);
    assign w_is_br   = (w_inst[6:0] == 7'b1100011) && (w_inst[14:13] != 2'b01);

    assign w_rd_ok   = ({1'b0, w_inst[11:7]}  < c_NREGS);
    assign w_rs1_ok  = ({1'b0, w_inst[19:15]} < c_NREGS);
    assign w_rs2_ok  = ({1'b0, w_inst[24:20]} < c_NREGS);
    assign w_idx_bad = ((w_is_add | w_is_addi) & ~w_rd_ok)
                     | ((w_is_add | w_is_addi | w_is_br) & ~w_rs1_ok)
                     | ((w_is_add | w_is_br) & ~w_rs2_ok);

    assign w_rs1     = w_rs1_ok ? r_regs[w_inst[15 +: c_AW]] : '0;
    assign w_rs2     = w_rs2_ok ? r_regs[w_inst[20 +: c_AW]] : '0;
    assign w_rd_idx  = w_inst[7 +: c_AW];

    assign w_imm_i   = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
    assign w_imm_b   = {{(XLEN-13){w_inst[31]}}, w_inst[31], w_inst[7],
                        w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_target  = r_pc + w_imm_b;

    always_comb begin
        w_taken = 1'b0;
        case (w_inst[14:12])
            3'b000:  w_taken = (w_rs1 == w_rs2);
            3'b001:  w_taken = (w_rs1 != w_rs2);
            3'b100:  w_taken = ($signed(w_rs1) <  $signed(w_rs2));
            3'b101:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
            3'b110:  w_taken = (w_rs1 <  w_rs2);
            3'b111:  w_taken = (w_rs1 >= w_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_fault   = ~(w_is_add | w_is_addi | w_is_br) | w_idx_bad
                     | (w_is_br & w_taken & w_target[1]);
    assign w_pc_next = (w_is_br && w_taken) ? w_target : r_pc + XLEN'(4);
    assign w_wdata   = w_rs1 + (w_is_add ? w_rs2 : w_imm_i);
    assign w_wen     = (w_is_add | w_is_addi) && (w_rd_idx != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: if (imem.imem_ack) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = r_retire ? S_FETCH : S_HALT;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retire  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        r_ir     <= imem.imem_rdata;
                        r_retire <= ~w_fault;
                    end
                end
                S_EXEC: begin
                    if (r_retire) begin
                        r_pc <= w_pc_next;
                        if (w_wen) r_regs[w_rd_idx] <= w_wdata;
                    end else begin
                        r_illegal <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with reset drops the request the instant reset is asserted.
    assign imem.imem_req  = (r_state == S_FETCH) & reset;
    assign imem.imem_addr = r_pc;
    assign retire         = r_retire;
    assign halted         = (r_state == S_HALT);
    assign illegal        = r_illegal;
    assign dbg_pc         = r_pc;
    assign dbg_rdata      = ((dbg_raddr != 5'd0) && ({1'b0, dbg_raddr} < c_NREGS))
                            ? r_regs[dbg_raddr[c_AW-1:0]] : '0;
endmodule
`default_nettype wire

// File: tb/tb_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_core
// Purpose  : Self-checking bench for mc_core: vector table, corner sequences,
//            random programs against an instruction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mc_core;
    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] TRAP = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        retire, halted, illegal;
    logic [31:0] dbg_pc, dbg_rdata;
    logic [4:0]  dbg_raddr = 5'd0;

    mc_core_if #(.XLEN(XLEN)) imem();

    mc_core #(.XLEN(XLEN), .RESET_PC(RPC), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .imem(imem), .retire(retire), .halted(halted),
        .illegal(illegal), .dbg_pc(dbg_pc), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int ack_delay = 0;
    int wait_cnt  = 0;
    int n_ret     = 0;
    int n_chk     = 0;
    int n_fail    = 0;

    initial begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem.imem_req) begin
                if (wait_cnt >= ack_delay) begin
                    imem.imem_ack   = 1'b1;
                    imem.imem_rdata = mem[imem.imem_addr[9:2]];
                    wait_cnt        = 0;
                end else begin
                    imem.imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem.imem_ack = 1'b0;
                wait_cnt      = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (retire) n_ret++;
    end

    function automatic logic [31:0] e_addi(input int rd, input int rs1, input int imm);
        logic [11:0] i12 = imm[11:0];
        return {i12, rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
    endfunction

    function automatic logic [31:0] e_add(input int rd, input int rs1, input int rs2);
        return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] e_br(input int f3, input int rs1, input int rs2, input int off);
        logic [12:0] o = off[12:0];
        return {o[12], o[10:5], rs2[4:0], rs1[4:0], f3[2:0], o[4:1], o[11], 7'b1100011};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic read_reg(input int idx, output logic [31:0] v);
        dbg_raddr = idx[4:0];
        #1;
        v = dbg_rdata;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = TRAP;
    endtask

    task automatic do_reset(input bit chk);
        logic [31:0] v;
        reset = 1'b0;
        @(posedge clk);
        #2;
        if (chk) begin
            check("rst imem_req", imem.imem_req, 0);
            check("rst retire", retire, 0);
            check("rst halted", halted, 0);
            check("rst illegal", illegal, 0);
            check("rst pc", dbg_pc, RPC);
            read_reg(1, v);
            check("rst x1", v, 0);
        end
        @(posedge clk);
        #2;
        n_ret = 0;
        reset = 1'b1;
    endtask

    task automatic wait_halt(input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (halted) ok = 1'b1;
        end
        check({nm, " halt reached"}, ok, 1);
    endtask

    typedef struct {
        logic [31:0] w [5];
        int          rchk;
        logic [31:0] rval;
        logic [31:0] pc_off;
        int          nret;
    } vec_t;
    vec_t vq[$];

    task automatic add_vec(input logic [31:0] w0, w1, w2, w3, w4, input int r,
                           input logic [31:0] v, input logic [31:0] pco, input int nr);
        vec_t t;
        t.w[0] = w0; t.w[1] = w1; t.w[2] = w2; t.w[3] = w3; t.w[4] = w4;
        t.rchk = r; t.rval = v; t.pc_off = pco; t.nret = nr;
        vq.push_back(t);
    endtask

    // Instruction-level reference: executes the program straight from mem.
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          m_ret;

    task automatic run_model();
        logic [31:0] w, a, b, immi, immb;
        bit stop = 1'b0, tk;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc  = RPC;
        m_ret = 0;
        for (int s = 0; s < 500 && !stop; s++) begin
            w    = mem[m_pc[9:2]];
            a    = m_regs[w[19:15]];
            b    = m_regs[w[24:20]];
            immi = {{20{w[31]}}, w[31:20]};
            immb = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0) begin
                if (w[11:7] != 5'd0) m_regs[w[11:7]] = a + b;
                m_pc += 4; m_ret++;
            end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
                if (w[11:7] != 5'd0) m_regs[w[11:7]] = a + immi;
                m_pc += 4; m_ret++;
            end else if (w[6:0] == 7'h63 && w[14:12] != 3'd2 && w[14:12] != 3'd3) begin
                case (w[14:12])
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    default: tk = (a >= b);
                endcase
                if (tk && ((m_pc + immb) % 4 != 0)) stop = 1'b1;
                else begin
                    m_pc = tk ? m_pc + immb : m_pc + 4;
                    m_ret++;
                end
            end else begin
                stop = 1'b1;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        int          cnt;
        logic [6:0]  rmask;
        int          f3s [6] = '{0, 1, 4, 5, 6, 7};

        // Directed vector table: program words, checked register, final PC offset, retires.
        add_vec(e_addi(1,0,5), e_addi(2,0,-3), e_add(3,1,2), TRAP, TRAP, 3, 32'd2, 12, 3);
        add_vec(e_addi(1,0,-1), e_addi(2,0,1), e_br(4,1,2,8), TRAP, e_addi(5,0,1), 5, 32'd1, 20, 4);
        add_vec(e_addi(1,0,-1), e_addi(2,0,1), e_br(6,1,2,8), TRAP, e_addi(5,0,1), 5, 32'd0, 12, 3);
        add_vec(e_addi(0,0,7), e_add(4,0,0), TRAP, TRAP, TRAP, 4, 32'd0, 8, 2);
        add_vec(e_addi(0,0,7), e_add(4,0,0), TRAP, TRAP, TRAP, 0, 32'd0, 8, 2);
        add_vec(e_br(0,0,0,6), TRAP, TRAP, TRAP, TRAP, 0, 32'd0, 0, 0);
        add_vec(TRAP, TRAP, TRAP, TRAP, TRAP, 1, 32'd0, 0, 0);
        add_vec(32'h4000_0033, TRAP, TRAP, TRAP, TRAP, 0, 32'd0, 0, 0);
        add_vec(e_addi(1,0,-1), e_br(7,1,0,8), TRAP, e_addi(6,0,3), TRAP, 6, 32'd3, 16, 3);
        add_vec(e_addi(1,0,4), e_addi(2,0,4), e_br(1,1,2,8), e_addi(7,1,-9), TRAP, 7, 32'hFFFF_FFFB, 16, 4);
        add_vec(e_addi(1,0,-2048), e_add(2,1,1), TRAP, TRAP, TRAP, 2, 32'hFFFF_F000, 8, 2);

        foreach (vq[i]) begin
            clear_mem();
            for (int k = 0; k < 5; k++) mem[64 + k] = vq[i].w[k];
            do_reset(i == 1);
            wait_halt($sformatf("vec%0d", i));
            check($sformatf("vec%0d pc", i), dbg_pc - RPC, vq[i].pc_off);
            check($sformatf("vec%0d retires", i), n_ret, vq[i].nret);
            check($sformatf("vec%0d illegal", i), illegal, 1);
            read_reg(vq[i].rchk, v);
            check($sformatf("vec%0d reg", i), v, vq[i].rval);
        end

        // Retire cadence with zero-wait memory: cycles 2, 4, 6 after release.
        clear_mem();
        mem[64] = e_addi(1,0,5); mem[65] = e_addi(2,0,-3); mem[66] = e_add(3,1,2);
        do_reset(0);
        #1;
        check("first req", imem.imem_req, 1);
        check("first addr", imem.imem_addr, RPC);
        rmask = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            rmask[c] = retire;
        end
        check("retire cadence", rmask, 7'b0101010);
        wait_halt("cadence");

        // Slow memory: request held stable until the ack, single retire.
        clear_mem();
        mem[64] = e_addi(1,0,1);
        ack_delay = 3;
        do_reset(0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (imem.imem_req && imem.imem_addr == RPC && !retire) cnt++;
        end
        check("req stable 4 cycles", cnt, 4);
        @(negedge clk);
        check("req drops in exec", imem.imem_req, 0);
        wait_halt("slow mem");
        check("slow mem retires", n_ret, 1);
        read_reg(1, v);
        check("slow mem x1", v, 1);
        check("halt pc held", dbg_pc, RPC + 4);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (imem.imem_req) cnt++;
        end
        check("no req after halt", cnt, 0);

        // Reset asserted mid-fetch and mid-exec.
        clear_mem();
        mem[64] = e_addi(5,0,9);
        ack_delay = 2;
        do_reset(0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("req async drop", imem.imem_req, 0);
        @(posedge clk);
        #2;
        ack_delay = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("exec cycle retire", retire, 1);
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        read_reg(5, v);
        check("exec abort x5", v, 0);
        check("exec abort pc", dbg_pc, RPC);
        wait_halt("rerun");
        read_reg(5, v);
        check("rerun x5", v, 9);

        // Random programs versus the reference model.
        for (int it = 0; it < 20; it++) begin
            clear_mem();
            for (int k = 0; k < 24; k++) begin
                int kind = $urandom_range(0, 9);
                int rd   = $urandom_range(0, 7);
                int ra   = $urandom_range(0, 7);
                int rb   = $urandom_range(0, 7);
                int imm  = int'($urandom_range(0, 4095)) - 2048;
                int off  = int'($urandom_range(1, 4)) * 4;
                if ($urandom_range(0, 15) == 0) off = 6;
                if (kind < 5)      mem[64 + k] = e_addi(rd, ra, imm);
                else if (kind < 7) mem[64 + k] = e_add(rd, ra, rb);
                else               mem[64 + k] = e_br(f3s[$urandom_range(0, 5)], ra, rb, off);
            end
            run_model();
            ack_delay = $urandom_range(0, 2);
            do_reset(0);
            wait_halt($sformatf("rnd%0d", it));
            check($sformatf("rnd%0d pc", it), dbg_pc, m_pc);
            check($sformatf("rnd%0d retires", it), n_ret, m_ret);
            check($sformatf("rnd%0d illegal", it), illegal, 1);
            for (int r = 1; r < 8; r++) begin
                read_reg(r, v);
                check($sformatf("rnd%0d x%0d", it, r), v, m_regs[r]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
